// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the keypad-entry digit bus. The key-entry block, the
// seven-segment decoder and bcd_entry_reader all agree on the bus shape and
// the special nibble codes through this package.
//
// Contents:
//    NDIG        number of BCD digits on the bus (index NDIG-1 is leftmost)
//    IDX_W       width of a digit index / decimal-point position
//    VAL_W       width of a binary value able to hold 10^NDIG-1
//    BLANK_CODE  nibble driven on unused leading positions
//    MINUS_CODE  nibble used as a leading minus sign (BCD_NEG_EN builds)
//    digit_bus_t packed digit bus type
//    reader_state_t  conversion FSM states
//    count_points / point_index  helpers for the decimal-point flags
// ---------------------------------------------------------------------------
package keypad_pkg;

   localparam int NDIG  = 8;
   localparam int IDX_W = $clog2(NDIG);
   localparam int VAL_W = 27;

   localparam logic [3:0] BLANK_CODE = 4'hF;
   localparam logic [3:0] MINUS_CODE = 4'hA;

   typedef logic [NDIG-1:0][3:0] digit_bus_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } reader_state_t;

   // Number of lit decimal points; anything above one is a malformed entry.
   function automatic logic [IDX_W:0] count_points(input logic [NDIG-1:0] fp);
      logic [IDX_W:0] n;
      n = '0;
      for (int i = 0; i < NDIG; i++) begin
         n = n + {{IDX_W{1'b0}}, fp[i]};
      end
      return n;
   endfunction

   // Position of the highest lit decimal point. Only meaningful when exactly
   // one point is lit; the caller forces zero otherwise.
   function automatic logic [IDX_W-1:0] point_index(input logic [NDIG-1:0] fp);
      logic [IDX_W-1:0] pos;
      pos = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (fp[i]) begin
            pos = IDX_W'(i);
         end
      end
      return pos;
   endfunction

endpackage

// File: rtl/bcd_mac10.sv
// ---------------------------------------------------------------------------
// bcd_mac10
// Combinational multiply-by-ten-and-add step used to fold one decimal digit
// into a running binary accumulator: result = acc*10 + digit, truncated to
// VAL_W bits. The multiply is built from two shifts and an add so no
// multiplier is inferred.
//
// Ports:
//    acc     in   [VAL_W-1:0]  running binary value
//    digit   in   [3:0]        decimal digit to append (0..9 expected)
//    result  out  [VAL_W-1:0]  acc*10 + digit, modulo 2^VAL_W
// ---------------------------------------------------------------------------
module bcd_mac10 #(
   parameter int VAL_W = 27
) (
   input  logic [VAL_W-1:0] acc,
   input  logic [3:0]       digit,
   output logic [VAL_W-1:0] result
);

   logic [VAL_W-1:0] times8;
   logic [VAL_W-1:0] times2;

   // Shifts are taken at VAL_W width so overflow simply drops off the top.
   assign times8 = acc << 3;
   assign times2 = acc << 1;
   assign result = times8 + times2 + VAL_W'(digit);

endmodule

// File: rtl/bcd_entry_reader.sv
// ---------------------------------------------------------------------------
// bcd_entry_reader
// Reader side of the keypad-entry digit bus. On a start pulse it snapshots
// the displayed digits and decimal-point flags, then walks the snapshot from
// the leftmost digit down, one digit per clock, producing the binary value,
// the number of fractional digits and an error flag for malformed entries.
//
// Optional feature (macro BCD_NEG_EN): a MINUS_CODE nibble in the leftmost
// position is read as a minus sign and reported on neg. Without the macro
// neg is tied low and MINUS_CODE is just another illegal code.
//
// Ports:
//    CLK          in   1           system clock
//    NRST         in   1           asynchronous active-low reset
//    start        in   1           single-cycle request to convert the bus
//    digits       in   digit_bus_t BCD digits, index NDIG-1 leftmost
//    flt_pt       in   [NDIG-1:0]  decimal-point flags, bit i after digit i
//    busy         out  1           conversion in progress
//    done         out  1           one-cycle pulse, results valid
//    value        out  [VAL_W-1:0] binary value of all digits
//    frac_digits  out  [IDX_W-1:0] digits right of the point, 0 if none
//    neg          out  1           entry carries a leading minus sign
//    err          out  1           malformed entry
// ---------------------------------------------------------------------------
module bcd_entry_reader
   import keypad_pkg::*;
(
   input  logic             CLK,
   input  logic             NRST,
   input  logic             start,
   input  digit_bus_t       digits,
   input  logic [NDIG-1:0]  flt_pt,
   output logic             busy,
   output logic             done,
   output logic [VAL_W-1:0] value,
   output logic [IDX_W-1:0] frac_digits,
   output logic             neg,
   output logic             err
);

   reader_state_t state;
   reader_state_t next_state;

   digit_bus_t       snap_digits;
   logic [NDIG-1:0]  snap_pt;
   logic [IDX_W-1:0] idx;
   logic [VAL_W-1:0] acc;
   logic             seen_sig;
   logic             err_acc;

   logic [3:0]       cur_digit;
   logic [3:0]       digit_val;
   logic             digit_err;
   logic             digit_sig;
   logic [VAL_W-1:0] mac_result;
   logic             last_digit;
   logic [IDX_W:0]   point_count;
   logic             point_err;
   logic [IDX_W-1:0] point_pos;

`ifdef BCD_NEG_EN
   logic             digit_minus;
   logic             neg_acc;
`endif

   // The digit under conversion always comes from the snapshot, so the bus
   // is free to change once start has been accepted.
   assign cur_digit  = snap_digits[idx];
   assign last_digit = (idx == '0);

   // Decimal-point decode works on the snapshot too. More than one lit
   // point is an error and reports zero fractional digits.
   assign point_count = count_points(snap_pt);
   assign point_err   = (point_count > 1);
   assign point_pos   = (point_count == 1) ? point_index(snap_pt) : '0;

   // Digit classification. Legal decimals feed the accumulator directly;
   // every other code contributes zero. A blank is only tolerated before the
   // first nonzero digit, so "1 3" with a gap is flagged while leading
   // blanks and leading zeros are not.
   always_comb begin
      digit_val = '0;
      digit_err = 1'b0;
      digit_sig = 1'b0;
`ifdef BCD_NEG_EN
      digit_minus = 1'b0;
`endif
      if (cur_digit <= 4'd9) begin
         digit_val = cur_digit;
         digit_sig = (cur_digit != 4'd0);
      end else if (cur_digit == BLANK_CODE) begin
         digit_err = seen_sig;
`ifdef BCD_NEG_EN
      end else if ((cur_digit == MINUS_CODE) && (idx == IDX_W'(NDIG-1))) begin
         digit_minus = 1'b1;
`endif
      end else begin
         digit_err = 1'b1;
      end
   end

   bcd_mac10 #(
      .VAL_W (VAL_W)
   ) u_mac10 (
      .acc    (acc),
      .digit  (digit_val),
      .result (mac_result)
   );

   // State register for the IDLE -> CONV -> DONE walk.
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and handshake outputs. start is only looked at in IDLE, so a
   // request arriving mid-conversion or during DONE is dropped, not queued.
   always_comb begin
      next_state = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = CONV;
            end
         end
         CONV: begin
            busy = 1'b1;
            if (last_digit) begin
               next_state = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Conversion datapath: snapshot on start, fold one digit per CONV cycle,
   // and on the final digit publish the results so they are already stable
   // while done is high. The published outputs are otherwise left alone, so
   // they keep the previous result throughout the next conversion.
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         snap_digits <= '0;
         snap_pt     <= '0;
         idx         <= '0;
         acc         <= '0;
         seen_sig    <= 1'b0;
         err_acc     <= 1'b0;
         value       <= '0;
         frac_digits <= '0;
         err         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  snap_digits <= digits;
                  snap_pt     <= flt_pt;
                  idx         <= IDX_W'(NDIG-1);
                  acc         <= '0;
                  seen_sig    <= 1'b0;
                  err_acc     <= 1'b0;
               end
            end
            CONV: begin
               acc      <= mac_result;
               seen_sig <= seen_sig | digit_sig;
               err_acc  <= err_acc | digit_err;
               idx      <= idx - 1'b1;
               if (last_digit) begin
                  value       <= mac_result;
                  err         <= err_acc | digit_err | point_err;
                  frac_digits <= point_pos;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef BCD_NEG_EN
   // The minus sign can only appear on the first CONV cycle, so it is
   // latched there and published alongside the other results.
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         neg_acc <= 1'b0;
         neg     <= 1'b0;
      end else begin
         if ((state == IDLE) && start) begin
            neg_acc <= 1'b0;
         end else if (state == CONV) begin
            neg_acc <= neg_acc | digit_minus;
            if (last_digit) begin
               neg <= neg_acc | digit_minus;
            end
         end
      end
   end
`else
   assign neg = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_entry_reader.sv
// ---------------------------------------------------------------------------
// tb_bcd_entry_reader
// Self-checking bench for bcd_entry_reader. Expected results come from a
// decimal reference model of the entry rules and are queued when a
// conversion is launched; a monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_bcd_entry_reader;
   import keypad_pkg::*;

`ifdef BCD_NEG_EN
   localparam bit NEG_EN = 1'b1;
`else
   localparam bit NEG_EN = 1'b0;
`endif

   typedef struct {
      logic [31:0] value;
      logic [31:0] frac;
      logic        neg;
      logic        err;
   } expect_t;

   logic             CLK = 1'b0;
   logic             NRST;
   logic             start;
   digit_bus_t       digits;
   logic [NDIG-1:0]  flt_pt;
   logic             busy;
   logic             done;
   logic [VAL_W-1:0] value;
   logic [IDX_W-1:0] frac_digits;
   logic             neg;
   logic             err;

   int checks   = 0;
   int failures = 0;

   expect_t sb_queue[$];
   logic [31:0] held_value = 0;

   bcd_entry_reader dut (
      .CLK         (CLK),
      .NRST        (NRST),
      .start       (start),
      .digits      (digits),
      .flt_pt      (flt_pt),
      .busy        (busy),
      .done        (done),
      .value       (value),
      .frac_digits (frac_digits),
      .neg         (neg),
      .err         (err)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   task automatic reportFail(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s actual=timeout expected=event", name);
   endtask

   // Reference model: reads the entry left to right as a person would.
   function automatic expect_t model(input digit_bus_t d, input logic [NDIG-1:0] fp);
      expect_t e;
      longint  v = 0;
      bit      seen = 0;
      int      pts = 0;
      int      pos = 0;
      e.err = 0;
      e.neg = 0;
      for (int i = NDIG-1; i >= 0; i--) begin
         int c = int'(d[i]);
         if (c < 10) begin
            v = v * 10 + c;
            if (c != 0) seen = 1;
         end else begin
            v = v * 10;
            if (c == 15) begin
               if (seen) e.err = 1;
            end else if (NEG_EN && c == 10 && i == NDIG-1) begin
               e.neg = 1;
            end else begin
               e.err = 1;
            end
         end
      end
      for (int i = 0; i < NDIG; i++) begin
         if (fp[i]) begin
            pts++;
            pos = i;
         end
      end
      if (pts > 1) e.err = 1;
      e.frac  = (pts == 1) ? 32'(pos) : 32'd0;
      e.value = 32'(v);
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding request.
   always @(negedge CLK) begin
      if (NRST && done) begin
         if (sb_queue.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_done actual=done expected=no_done");
         end else begin
            expect_t e;
            e = sb_queue.pop_front();
            checkOutput("value", 32'(value), e.value);
            checkOutput("frac_digits", 32'(frac_digits), e.frac);
            checkOutput("neg", 32'(neg), 32'(e.neg));
            checkOutput("err", 32'(err), 32'(e.err));
         end
      end
   end

   // Launch one conversion, scramble the bus afterwards, count busy cycles
   // and optionally fire a second start at cycle second_start.
   task automatic applyStimulus(input digit_bus_t d, input logic [NDIG-1:0] fp,
                                input int second_start);
      expect_t e;
      int busy_cycles = 0;
      int guard = 0;
      bit got_done = 0;
      while ((busy || done) && guard < 20) begin
         @(posedge CLK); #1;
         guard++;
      end
      if (guard >= 20) reportFail("idle_wait");
      e = model(d, fp);
      @(posedge CLK); #1;
      digits = d;
      flt_pt = fp;
      start  = 1'b1;
      sb_queue.push_back(e);
      @(posedge CLK); #1;
      start  = 1'b0;
      digits = digit_bus_t'($urandom);
      flt_pt = NDIG'($urandom);
      for (int cyc = 0; cyc < 30; cyc++) begin
         if (done) begin
            got_done = 1;
            break;
         end
         if (busy) busy_cycles++;
         if (cyc == 4) checkOutput("hold_value", 32'(value), held_value);
         start = (cyc == second_start);
         @(posedge CLK); #1;
         start = 1'b0;
      end
      if (!got_done) reportFail("done_timeout");
      checkOutput("busy_cycles", 32'(busy_cycles), 32'd8);
      checkOutput("busy_in_done", 32'(busy), 32'd0);
      held_value = e.value;
      @(posedge CLK); #1;
      checkOutput("done_one_cycle", 32'(done), 32'd0);
   endtask

   function automatic digit_bus_t random_entry();
      digit_bus_t d;
      int lead = $urandom_range(0, NDIG);
      for (int i = 0; i < NDIG; i++) begin
         d[i] = (i >= NDIG - lead) ? BLANK_CODE : 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) d[$urandom_range(0, NDIG-1)] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 7) == 0) d[NDIG-1] = MINUS_CODE;
      return d;
   endfunction

   function automatic logic [NDIG-1:0] random_points();
      case ($urandom_range(0, 3))
         0:       return '0;
         3:       return NDIG'($urandom);
         default: return NDIG'(1) << $urandom_range(0, NDIG-1);
      endcase
   endfunction

   initial begin
      NRST   = 1'b0;
      start  = 1'b0;
      digits = '0;
      flt_pt = '0;
      repeat (3) @(posedge CLK);
      #1;
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_value", 32'(value), 32'd0);
      checkOutput("reset_frac", 32'(frac_digits), 32'd0);
      checkOutput("reset_neg", 32'(neg), 32'd0);
      checkOutput("reset_err", 32'(err), 32'd0);
      NRST = 1'b1;

      applyStimulus(32'hFFF12345, 8'b0000_0000, -1);
      applyStimulus(32'hFFF12345, 8'b0000_0100, -1);
      applyStimulus(32'h99999999, 8'b0000_0000, -1);
      applyStimulus(32'h99999999, 8'b0001_0001, -1);
      applyStimulus(32'hF1F30000, 8'b0000_0000, -1);
      applyStimulus(32'hFFFFFFFF, 8'b0000_0000, -1);
      applyStimulus(32'h00000000, 8'b1000_0000, -1);
      applyStimulus(32'hAFFFFF42, 8'b0000_0000, -1);
      applyStimulus(32'h12345678, 8'b0000_0001, -1);

      // Abort a conversion with reset: outputs clear at once, no done.
      @(posedge CLK); #1;
      digits = 32'h87654321;
      start  = 1'b1;
      @(posedge CLK); #1;
      start  = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      NRST = 1'b0;
      #1;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      checkOutput("abort_value", 32'(value), 32'd0);
      checkOutput("abort_frac", 32'(frac_digits), 32'd0);
      checkOutput("abort_err", 32'(err), 32'd0);
      held_value = 0;
      repeat (2) @(posedge CLK);
      #1;
      NRST = 1'b1;
      repeat (12) @(posedge CLK);
      #1;
      checkOutput("abort_idle_busy", 32'(busy), 32'd0);

      // A second start mid-conversion must not produce a second done.
      applyStimulus(32'hFFF12345, 8'b0000_0100, 3);
      repeat (12) @(posedge CLK);

      for (int n = 0; n < 150; n++) begin
         applyStimulus(random_entry(), random_points(),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1);
      end

      repeat (12) @(posedge CLK);
      #1;
      checkOutput("scoreboard_drained", 32'(sb_queue.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
